// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU requantization path.
// Imported by the requant top and its lane datapath.
package npu_pkg;

  localparam int ACT_WIDTH = 8;
  localparam int ACC_WIDTH = 2 * ACT_WIDTH;
  localparam int ACT_MAX   = 127;
  localparam int ACT_MIN   = -128;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// One accumulator -> activation: round, shift, saturate, optional ReLU.
// Purely combinational.
module requant_lane
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = ACT_WIDTH
) (
  input  logic [2*DATA_WIDTH-1:0] i_acc,
  input  logic [3:0]              i_shift,
  input  logic                    i_relu_en,
  output logic [DATA_WIDTH-1:0]   o_act
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int SMAX = (DATA_WIDTH == 8) ? ACT_MAX
                      : (1 << (DATA_WIDTH - 1)) - 1;
  localparam int SMIN = (DATA_WIDTH == 8) ? ACT_MIN
                      : -(1 << (DATA_WIDTH - 1));
  localparam logic signed [AW:0] MAXV = (AW+1)'(SMAX);
  localparam logic signed [AW:0] MINV = (AW+1)'(SMIN);
  localparam logic signed [AW:0] ONE  = (AW+1)'(1);

  logic signed [AW:0] w_ext;
  logic signed [AW:0] w_rnd;
  logic signed [AW:0] w_sum;
  logic signed [AW:0] w_shr;
  logic [DATA_WIDTH-1:0] w_sat;

  // One guard bit keeps acc + rounding term from wrapping.
  always_comb begin
    w_ext = {i_acc[AW-1], i_acc};
    w_rnd = '0;
    if (i_shift != 4'd0)
      w_rnd = ONE << (i_shift - 4'd1);
    w_sum = w_ext + w_rnd;
    w_shr = w_sum >>> i_shift;
  end

  always_comb begin
    w_sat = w_shr[DATA_WIDTH-1:0];
    if (w_shr > MAXV)
      w_sat = MAXV[DATA_WIDTH-1:0];
    else if (w_shr < MINV)
      w_sat = MINV[DATA_WIDTH-1:0];
  end

  always_comb begin
    o_act = w_sat;
    if (i_relu_en && w_sat[DATA_WIDTH-1])
      o_act = '0;
  end

endmodule

// File: rtl/npu_requant.sv
// Post-MAC requantization: capture a PE accumulator set,
// then stream requantized activations out in LANES-wide beats.
module npu_requant
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = ACT_WIDTH,
  parameter int DATA_COPIES = 32,
  parameter int LANES       = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_acc,
  input  logic                              i_acc_load,
  input  logic [3:0]                        i_shift,
  input  logic                              i_relu_en,
  output logic [LANES*DATA_WIDTH-1:0]       o_data,
  output logic                              o_vld,
  input  logic                              i_ready,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_overrun,
  input  logic                              i_overrun_clr
);

  localparam int AW    = 2 * DATA_WIDTH;
  localparam int BEATS = DATA_COPIES / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e r_state;
  state_e w_state_nxt;

  logic [AW-1:0]   r_buf [BEATS][LANES];
  logic [3:0]      r_shift;
  logic            r_relu;
  logic [CW-1:0]   r_cnt;
  logic [LANES*DATA_WIDTH-1:0] r_data;
  logic            r_vld;
  logic            r_last;
  logic            r_ovr;

  logic            w_hs;
  logic            w_hs_last;
  logic            w_load;
  logic            w_drop;
  logic            w_issue;
  logic [BW-1:0]   w_beat;
  logic [AW-1:0]   w_sel [LANES];
  logic [LANES*DATA_WIDTH-1:0] w_act;

  assign w_hs      = r_vld & i_ready;
  assign w_hs_last = w_hs & r_last;
  assign w_load    = i_acc_load
                   & ((r_state == ST_IDLE) | w_hs_last);
  assign w_drop    = i_acc_load & ~w_load;
  // Issue only while beats remain; the last handshake and a new
  // load share an edge, so beat 0 of the next set trails by one.
  assign w_issue   = (r_state == ST_DRAIN)
                   & (r_cnt != CW'(BEATS))
                   & (~r_vld | i_ready);
  assign w_beat    = r_cnt[BW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_load) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_hs_last && !w_load) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < BEATS; b++)
        for (int l = 0; l < LANES; l++)
          r_buf[b][l] <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_load) begin
      for (int b = 0; b < BEATS; b++)
        for (int l = 0; l < LANES; l++)
          r_buf[b][l] <= i_acc[(b*LANES+l)*AW +: AW];
      r_shift <= i_shift;
      r_relu  <= i_relu_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (w_load)  r_cnt <= '0;
    else if (w_issue) r_cnt <= r_cnt + CW'(1);
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      w_sel[l] = r_buf[w_beat][l];
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    requant_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_acc     (w_sel[j]),
      .i_shift   (r_shift),
      .i_relu_en (r_relu),
      .o_act     (w_act[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else if (w_issue) begin
      r_data <= w_act;
      r_vld  <= 1'b1;
      r_last <= (r_cnt == CW'(BEATS - 1));
    end else if (w_hs) begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_ovr <= 1'b0;
    else if (w_drop)        r_ovr <= 1'b1;
    else if (i_overrun_clr) r_ovr <= 1'b0;
  end

  assign o_data    = r_data;
  assign o_vld     = r_vld;
  assign o_last    = r_last;
  assign o_busy    = (r_state == ST_DRAIN);
  assign o_overrun = r_ovr;

endmodule

// File: tb/tb_npu_requant.sv
// Directed bench for npu_requant with an expected-beat scoreboard.
// Expected beats come from an integer reference of the lane math.
module tb_npu_requant;

  localparam int DW = 8;
  localparam int NC = 32;
  localparam int NL = 8;
  localparam int NB = NC / NL;

  logic              clk;
  logic              rst_n;
  logic [NC*2*DW-1:0] acc;
  logic              load;
  logic [3:0]        shift;
  logic              relu;
  logic [NL*DW-1:0]  o_data;
  logic              o_vld;
  logic              ready;
  logic              o_last;
  logic              o_busy;
  logic              o_overrun;
  logic              ovr_clr;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_data [$];
  bit          exp_last [$];

  npu_requant #(
    .DATA_WIDTH  (DW),
    .DATA_COPIES (NC),
    .LANES       (NL)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_acc         (acc),
    .i_acc_load    (load),
    .i_shift       (shift),
    .i_relu_en     (relu),
    .o_data        (o_data),
    .o_vld         (o_vld),
    .i_ready       (ready),
    .o_last        (o_last),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .i_overrun_clr (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rq(input logic [15:0] a,
                                    input int sh, input bit rl);
    int v;
    v = int'(signed'(a));
    if (sh > 0) v = v + (1 << (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (rl && v < 0) v = 0;
    return 8'(v);
  endfunction

  task automatic push_set();
    logic [63:0] d;
    for (int k = 0; k < NB; k++) begin
      d = '0;
      for (int j = 0; j < NL; j++)
        d[j*8 +: 8] = rq(acc[(k*NL+j)*16 +: 16], int'(shift), relu);
      exp_data.push_back(d);
      exp_last.push_back(k == NB - 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_acc();
    for (int n = 0; n < NC; n++)
      acc[n*16 +: 16] = 16'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, o_busy}, 64'd0);
  endtask

  // A beat seen valid+ready here is accepted on the next edge.
  always @(negedge clk) begin
    if (rst_n && o_vld && ready) begin
      if (exp_data.size() == 0) begin
        chk("sb_extra_beat", 64'd1, 64'd0);
      end else begin
        chk("sb_data", o_data, exp_data.pop_front());
        chk("sb_last", {63'd0, o_last},
            {63'd0, exp_last.pop_front()});
      end
    end
  end

  initial begin
    logic [63:0] held;
    rst_n   = 1'b0;
    acc     = '0;
    load    = 1'b0;
    shift   = '0;
    relu    = 1'b0;
    ready   = 1'b1;
    ovr_clr = 1'b0;
    #12;
    chk("rst_vld", {63'd0, o_vld}, 64'd0);
    chk("rst_last", {63'd0, o_last}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_ovr", {63'd0, o_overrun}, 64'd0);
    chk("rst_data", o_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // basic scaling and rounding
    rand_acc();
    acc[0*16 +: 16] = 16'h0100;
    acc[1*16 +: 16] = 16'h0018;
    acc[2*16 +: 16] = 16'hFFE8;
    shift = 4'd4;
    relu  = 1'b0;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    chk("lat_busy", {63'd0, o_busy}, 64'd1);
    chk("lat_vld0", {63'd0, o_vld}, 64'd0);
    tick();
    chk("lat_vld1", {63'd0, o_vld}, 64'd1);
    chk("scale", {56'd0, o_data[7:0]}, 64'h10);
    chk("rnd_pos", {56'd0, o_data[15:8]}, 64'h02);
    chk("rnd_neg", {56'd0, o_data[23:16]}, 64'hFF);
    wait_idle("idle_a");

    // saturation, then with ReLU
    for (int r = 0; r < 2; r++) begin
      rand_acc();
      acc[0*16 +: 16] = 16'h7FFF;
      acc[1*16 +: 16] = 16'h8000;
      shift = 4'd0;
      relu  = (r == 1);
      load  = 1'b1;
      push_set();
      tick();
      load = 1'b0;
      tick();
      chk("sat_hi", {56'd0, o_data[7:0]}, 64'h7F);
      chk(r ? "relu_lo" : "sat_lo", {56'd0, o_data[15:8]},
          r ? 64'h00 : 64'h80);
      wait_idle("idle_sat");
    end

    // ordering and throughput
    for (int n = 0; n < NC; n++)
      acc[n*16 +: 16] = 16'(n << 4);
    shift = 4'd4;
    relu  = 1'b0;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    for (int k = 0; k < NB; k++) begin
      tick();
      chk("ord_vld", {63'd0, o_vld}, 64'd1);
      chk("ord_slot", {56'd0, o_data[63:56]}, 64'(k*8+7));
      chk("ord_last", {63'd0, o_last}, 64'(k == NB - 1));
    end
    tick();
    chk("ord_busy_fall", {63'd0, o_busy}, 64'd0);
    chk("ord_vld_fall", {63'd0, o_vld}, 64'd0);

    // backpressure during beat 1, dropped load, overrun flag
    rand_acc();
    shift = 4'd3;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    tick();
    tick();
    ready = 1'b0;
    held  = o_data;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_vld", {63'd0, o_vld}, 64'd1);
      chk("bp_data", o_data, held);
    end
    rand_acc();
    load = 1'b1;
    tick();
    chk("drop_ovr", {63'd0, o_overrun}, 64'd1);
    chk("drop_data", o_data, held);
    ovr_clr = 1'b1;
    tick();
    chk("ovr_set_wins", {63'd0, o_overrun}, 64'd1);
    load = 1'b0;
    tick();
    chk("ovr_clr", {63'd0, o_overrun}, 64'd0);
    ovr_clr = 1'b0;
    ready   = 1'b1;
    wait_idle("idle_bp");

    // back-to-back sets
    rand_acc();
    shift = 4'd2;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    for (int k = 0; k < NB; k++) tick();
    chk("b2b_last", {63'd0, o_last & o_vld}, 64'd1);
    rand_acc();
    shift = 4'd5;
    relu  = 1'b1;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    chk("b2b_busy", {63'd0, o_busy}, 64'd1);
    chk("b2b_bubble", {63'd0, o_vld}, 64'd0);
    tick();
    chk("b2b_beat0", {63'd0, o_vld}, 64'd1);
    chk("b2b_ovr", {63'd0, o_overrun}, 64'd0);
    wait_idle("idle_b2b");

    // asynchronous reset mid-drain
    rand_acc();
    shift = 4'd1;
    relu  = 1'b0;
    load  = 1'b1;
    push_set();
    tick();
    load = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", {63'd0, o_vld}, 64'd0);
    chk("mrst_last", {63'd0, o_last}, 64'd0);
    chk("mrst_busy", {63'd0, o_busy}, 64'd0);
    chk("mrst_data", o_data, 64'd0);
    exp_data.delete();
    exp_last.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mrst_stay", {63'd0, o_busy | o_vld}, 64'd0);
    chk("sb_empty", 64'(exp_data.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_requant.md
# npu_requant

Post-MAC requantization stage directly downstream of the PE MAC array. It captures the `DATA_COPIES` signed 16-bit accumulators the PE exposes when a MAC pass completes. It then rounds, shifts, saturates and optionally ReLU-clamps each one to a signed 8-bit activation. The results stream out over a valid/ready port in beats of `LANES` activations, freeing the PE to start its next accumulation while results drain.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: activation width; accumulator width is `2*DATA_WIDTH`.
- `DATA_COPIES`, default 32: accumulators per PE; must be a multiple of `LANES`.
- `LANES`, default 8: activations per output beat; `BEATS = DATA_COPIES/LANES` (default 4).

Ports:
- `i_clk`, in, 1: sole clock, rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_acc`, in, `DATA_COPIES*2*DATA_WIDTH`: PE accumulators; lane *n* occupies bits `[2*DATA_WIDTH*n +: 2*DATA_WIDTH]`, two's complement.
- `i_acc_load`, in, 1: single-cycle strobe; `i_acc` is valid this cycle.
- `i_shift`, in, 4: right-shift amount 0..15; sampled with `i_acc_load`.
- `i_relu_en`, in, 1: clamp negatives to 0; sampled with `i_acc_load`.
- `o_data`, out, `LANES*DATA_WIDTH`: beat payload; slot *j* occupies `[DATA_WIDTH*j +: DATA_WIDTH]`.
- `o_vld`, out, 1: `o_data` valid.
- `i_ready`, in, 1: consumer accepts the beat.
- `o_last`, out, 1: final beat of the current set.
- `o_busy`, out, 1: a captured set has not fully drained.
- `o_overrun`, out, 1: sticky; a load was dropped.
- `i_overrun_clr`, in, 1: clears `o_overrun`.

## Operation
- **States:**
  - `IDLE` → `DRAIN` on an accepted load.
  - `DRAIN` → `IDLE` when the last beat is accepted and there is no same-cycle load.
  - `DRAIN` → `DRAIN` when the last beat is accepted together with an accepted load (back-to-back sets).
- **Load acceptance:** a load is accepted when `i_acc_load` is high and either
  - the state is `IDLE`, or
  - the last beat is handshaking this cycle (`o_vld & i_ready & o_last`).
- **Capture:** an accepted load writes all of `i_acc`, `i_shift` and `i_relu_en` into the capture buffer and clears the beat counter.
- **Dropped load:** `i_acc_load` while busy and not handshaking the last beat is ignored, the buffer is untouched, and `o_overrun` is set.
- **Overrun flag:** `i_overrun_clr` clears it; a set and a clear in the same cycle leave it set.
- **Beat content:** beat *k* (0..`BEATS-1`) carries accumulator lanes `k*LANES` .. `k*LANES+LANES-1`, with lane `k*LANES+j` in slot *j*.
- **Per-lane arithmetic** (widths are exact):
  - Sign-extend the accumulator to 17 bits.
  - If shift > 0, add `1 << (shift-1)` (round half up); shift 0 adds nothing.
  - Arithmetic right shift by `shift`.
  - Saturate to [-128, 127].
  - If ReLU is enabled, map negative results to 0.
- **Handshake:**
  - The output register loads a new beat when `!o_vld || i_ready`.
  - While `o_vld` is high and `i_ready` is low, `o_data`, `o_last` and `o_vld` hold stable.
  - `o_vld` is never withdrawn without a handshake.
- **Busy:** `o_busy` is high from the accepted-load edge until the edge at which the last beat is accepted, unless a back-to-back load is accepted on that edge.

## Timing
- **Reset values:** state `IDLE`; `o_vld`=0, `o_last`=0, `o_busy`=0, `o_overrun`=0, `o_data`=0; buffer and counter cleared.
- **Latency:** a load sampled at edge E0 makes `o_busy` high after E0. Beat 0 is registered at E1, so `o_vld` is high after E1.
- **Throughput:** with `i_ready` held high, `BEATS` consecutive valid cycles per set.
- **Back-to-back sets:** beat 0 of the new set follows the old last beat with exactly one bubble cycle.
- **Asynchronous reset mid-drain:** immediately returns every output to its reset value. The partially drained set is discarded, not resumed.
- **No combinational paths** from `i_ready` to `o_vld` or `o_data`.

## Structure
- **Shared package `npu_pkg`:**
  - `ACC_WIDTH = 2*DATA_WIDTH`.
  - `ACT_MAX = 127`, `ACT_MIN = -128`.
  - The state enum (`ST_IDLE`, `ST_DRAIN`).
- **Sub-module `requant_lane`:** purely combinational; inputs are one accumulator plus shift and ReLU; output is one 8-bit activation. The top instantiates `LANES` copies, fed through a beat-select mux from the capture buffer.
- **Top contents:** FSM, beat counter, capture buffer, output register and overrun flag.

## Test plan
- **Basic scaling:** load with lane 0 = 0x0100, shift=4, no ReLU → beat 0 slot 0 = 0x10.
- **Rounding:**
  - lane = 0x0018 (24), shift 4 → 0x02.
  - lane = 0xFFE8 (-24), shift 4 → 0xFF.
- **Saturation and ReLU, shift 0:**
  - 0x7FFF → 0x7F and 0x8000 → 0x80.
  - Same inputs with ReLU enabled → 0x7F and 0x00.
- **Ordering:** lane *n* = *n*<<4, shift 4, `i_ready`=1 → 4 beats on consecutive cycles.
  - Beat *k* slot *j* = `k*8+j`.
  - `o_last` only on beat 3; `o_busy` falls on the last beat's accept edge.
- **Backpressure:** `i_ready` held low 5 cycles during beat 1 → `o_data` and `o_vld` stable for those cycles, no beat lost or duplicated.
- **Overrun and back-to-back:**
  - Load during beat 1 → dropped, `o_overrun`=1, output data unchanged.
  - Load coincident with the last-beat handshake → accepted; the new beat 0 appears after one bubble.
  - Mid-drain reset → all outputs return to 0.
